// File: rtl/mic1_mem.sv
// Main-memory responder for the MIC-1 core: word data port, byte fetch port,
// preload loader and one memory-mapped output register. One-cycle responses.
module mic1_mem #(
    parameter int          WORDS   = 1024,
    parameter logic [31:0] IO_ADDR = 32'h0000_FFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] mem_rdata,
    input  logic [31:0] mem_addr_instr,
    input  logic        mem_fetch,
    output logic [7:0]  mem_rd_instr,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ready,
    output logic [31:0] io_out,
    output logic        io_out_valid,
    output logic        err
);
    localparam int          AW  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [31:0] W32 = 32'(WORDS);

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_mem [WORDS];
    logic [31:0] r_rdata;
    logic [7:0]  r_instr;
    logic [31:0] r_io;
    logic        r_io_vld;
    logic        r_err;

    logic          w_load, w_run, w_ld_hs, w_ld_in;
    logic          w_d_io, w_d_arr, w_d_bad;
    logic          w_rd, w_wr, w_ft;
    logic [31:0]   w_f_word;
    logic          w_f_in;
    logic [31:0]   w_f_data;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [31:0]   w_wdata;
    logic [7:0]    w_f_byte;

    assign w_load   = (r_state == S_LOAD);
    assign w_run    = (r_state == S_RUN);
    assign w_ld_hs  = w_load && ld_valid;
    assign w_ld_in  = (ld_addr < W32);
    // The output register shadows any array word at the same address.
    assign w_d_io   = (mem_addr == IO_ADDR);
    assign w_d_arr  = (mem_addr < W32) && !w_d_io;
    assign w_d_bad  = !w_d_io && !w_d_arr;
    assign w_rd     = w_run && mem_read;
    assign w_wr     = w_run && mem_write;
    assign w_ft     = w_run && mem_fetch;
    assign w_f_word = {2'b00, mem_addr_instr[31:2]};
    assign w_f_in   = (w_f_word < W32);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_LOAD:  if (w_ld_hs && ld_last) w_state_nx = S_RUN;
            default: w_state_nx = S_RUN;
        endcase
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (resetn && w_ld_hs && w_ld_in) begin
            w_we    = 1'b1;
            w_waddr = ld_addr[AW-1:0];
            w_wdata = ld_data;
        end else if (resetn && w_wr && w_d_arr) begin
            w_we    = 1'b1;
            w_waddr = mem_addr[AW-1:0];
            w_wdata = mem_wdata;
        end
    end

    // Fetch of a word being written this cycle sees the new data.
    always_comb begin
        w_f_data = r_mem[w_f_word[AW-1:0]];
        if (w_wr && w_d_arr && (mem_addr == w_f_word))
            w_f_data = mem_wdata;
        case (mem_addr_instr[1:0])
            2'd0:    w_f_byte = w_f_data[31:24];
            2'd1:    w_f_byte = w_f_data[23:16];
            2'd2:    w_f_byte = w_f_data[15:8];
            default: w_f_byte = w_f_data[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_LOAD;
            r_rdata  <= '0;
            r_instr  <= '0;
            r_io     <= '0;
            r_io_vld <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_io_vld <= 1'b0;
            if (w_ld_hs && !w_ld_in)
                r_err <= 1'b1;
            if (w_rd) begin
                if (w_d_bad) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end else if (w_wr) begin
                    r_rdata <= mem_wdata;
                end else if (w_d_io) begin
                    r_rdata <= r_io;
                end else begin
                    r_rdata <= r_mem[mem_addr[AW-1:0]];
                end
            end
            if (w_wr) begin
                if (w_d_io) begin
                    r_io     <= mem_wdata;
                    r_io_vld <= 1'b1;
                end else if (w_d_bad) begin
                    r_err <= 1'b1;
                end
            end
            if (w_ft) begin
                if (w_f_in) begin
                    r_instr <= w_f_byte;
                end else begin
                    r_instr <= '0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    assign mem_rdata    = r_rdata;
    assign mem_rd_instr = r_instr;
    assign io_out       = r_io;
    assign io_out_valid = r_io_vld;
    assign err          = r_err;
    assign ld_ready     = w_load;
    assign ready        = w_run;
endmodule

// File: tb/tb_mic1_mem.sv
// Directed, table-driven bench for mic1_mem.
module tb_mic1_mem;
    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, mem_addr_instr;
    logic        mem_read, mem_write, mem_fetch;
    logic [7:0]  mem_rd_instr;
    logic        ld_valid, ld_last, ld_ready, ready, io_out_valid, err;
    logic [31:0] ld_addr, ld_data, io_out;

    localparam int          WORDS   = 1024;
    localparam logic [31:0] IO_ADDR = 32'h0000_FFFF;

    mic1_mem #(.WORDS(WORDS), .IO_ADDR(IO_ADDR)) dut (
        .clk(clk), .resetn(resetn),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata),
        .mem_addr_instr(mem_addr_instr), .mem_fetch(mem_fetch),
        .mem_rd_instr(mem_rd_instr),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .ready(ready),
        .io_out(io_out), .io_out_valid(io_out_valid), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, ft;
        logic [31:0] addr, wdata, iaddr;
        logic [31:0] e_rdata;
        logic [7:0]  e_instr;
        logic        e_iov;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_read = 0; mem_write = 0; mem_fetch = 0;
        ld_valid = 0; ld_last = 0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d, input logic last);
        ld_valid = 1; ld_addr = a; ld_data = d; ld_last = last;
        step();
        ld_valid = 0; ld_last = 0;
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic ft,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] iaddr, input logic [31:0] e_rdata,
                                input logic [7:0] e_instr, input logic e_iov);
        vec_t v;
        v.rd = rd; v.wr = wr; v.ft = ft; v.addr = addr; v.wdata = wdata;
        v.iaddr = iaddr; v.e_rdata = e_rdata; v.e_instr = e_instr; v.e_iov = e_iov;
        return v;
    endfunction

    vec_t vt[15];

    initial begin
        vt[0]  = mk(0,0,1, 0,        0,            0,  32'h0,          8'h11, 0);
        vt[1]  = mk(0,0,1, 0,        0,            1,  32'h0,          8'h22, 0);
        vt[2]  = mk(0,0,1, 0,        0,            2,  32'h0,          8'h33, 0);
        vt[3]  = mk(0,0,1, 0,        0,            3,  32'h0,          8'h44, 0);
        vt[4]  = mk(0,0,1, 0,        0,            4,  32'h0,          8'hCA, 0);
        vt[5]  = mk(1,0,0, 0,        0,            0,  32'h11223344,   8'hCA, 0);
        vt[6]  = mk(1,1,0, 5,        32'hDEADBEEF, 0,  32'hDEADBEEF,   8'hCA, 0);
        vt[7]  = mk(1,0,0, 5,        0,            0,  32'hDEADBEEF,   8'hCA, 0);
        vt[8]  = mk(0,1,0, IO_ADDR,  32'h2A,       0,  32'hDEADBEEF,   8'hCA, 1);
        vt[9]  = mk(0,1,0, IO_ADDR,  32'h2A,       0,  32'hDEADBEEF,   8'hCA, 1);
        vt[10] = mk(0,0,0, 0,        0,            0,  32'hDEADBEEF,   8'hCA, 0);
        vt[11] = mk(1,0,0, IO_ADDR,  0,            0,  32'h2A,         8'hCA, 0);
        vt[12] = mk(1,0,0, 1023,     0,            0,  32'h5A5A5A5A,   8'hCA, 0);
        vt[13] = mk(0,1,1, 6,        32'h01020304, 26, 32'h5A5A5A5A,   8'h03, 0);
        vt[14] = mk(0,0,0, 0,        0,            0,  32'h5A5A5A5A,   8'h03, 0);

        resetn = 0; idle();
        mem_addr = 0; mem_wdata = 0; mem_addr_instr = 0; ld_addr = 0; ld_data = 0;
        step(); step();
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_instr", {24'h0, mem_rd_instr}, 0);
        chk("rst_io", io_out, 0);
        chk("rst_iov", {31'h0, io_out_valid}, 0);
        chk("rst_err", {31'h0, err}, 0);
        chk("rst_ldrdy", {31'h0, ld_ready}, 1);
        chk("rst_ready", {31'h0, ready}, 0);

        // LOAD phase with a core read strobe held high throughout
        resetn = 1;
        mem_read = 1; mem_addr = 0;
        load(32'd1023, 32'h5A5A5A5A, 0);
        load(32'd0, 32'h11223344, 0);
        chk("load_rdata", mem_rdata, 0);
        chk("load_ready", {31'h0, ready}, 0);
        load(32'd1, 32'hCAFEBABE, 1);
        chk("trans_ready", {31'h0, ready}, 1);
        chk("trans_ldrdy", {31'h0, ld_ready}, 0);
        chk("trans_rdata", mem_rdata, 0);
        mem_read = 0;

        for (int i = 0; i < 15; i++) begin
            mem_read = vt[i].rd; mem_write = vt[i].wr; mem_fetch = vt[i].ft;
            mem_addr = vt[i].addr; mem_wdata = vt[i].wdata; mem_addr_instr = vt[i].iaddr;
            step();
            chk($sformatf("v%0d_rdata", i), mem_rdata, vt[i].e_rdata);
            chk($sformatf("v%0d_instr", i), {24'h0, mem_rd_instr}, {24'h0, vt[i].e_instr});
            chk($sformatf("v%0d_iov", i), {31'h0, io_out_valid}, {31'h0, vt[i].e_iov});
            chk($sformatf("v%0d_err", i), {31'h0, err}, 0);
        end
        idle();
        chk("io_out", io_out, 32'h2A);

        // Out-of-range read and fetch
        mem_read = 1; mem_addr = WORDS; mem_fetch = 1; mem_addr_instr = 4 * WORDS;
        step(); idle();
        chk("oor_rdata", mem_rdata, 0);
        chk("oor_instr", {24'h0, mem_rd_instr}, 0);
        chk("oor_err", {31'h0, err}, 1);
        step(); step(); step();
        chk("err_sticky", {31'h0, err}, 1);
        mem_read = 1; mem_addr = 6;
        step(); idle();
        chk("rd6", mem_rdata, 32'h01020304);

        // Reset mid-run, then reload with only a last word
        resetn = 0;
        step();
        chk("mrst_ready", {31'h0, ready}, 0);
        chk("mrst_ldrdy", {31'h0, ld_ready}, 1);
        chk("mrst_err", {31'h0, err}, 0);
        chk("mrst_rdata", mem_rdata, 0);
        resetn = 1;
        load(WORDS + 3, 32'h99, 0);
        chk("ld_oor_err", {31'h0, err}, 1);
        chk("ld_oor_state", {31'h0, ready}, 0);
        load(32'd10, 32'h77, 1);
        chk("reload_ready", {31'h0, ready}, 1);
        mem_read = 1; mem_addr = 0;
        step();
        chk("keep0", mem_rdata, 32'h11223344);
        mem_addr = 10;
        step();
        chk("rd10", mem_rdata, 32'h77);
        mem_addr = 5;
        step(); idle();
        chk("keep5", mem_rdata, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
